// File: rtl/npc_btb_predictor.sv
// Fetch PC register with a direct-mapped BTB (2-bit counters) that predicts the next fetch address.
// Branches are resolved in ID; a mispredicted resolution redirects fetch and flushes IF.
module npc_btb_predictor #(
  parameter int          ENTRIES    = 16,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter bit          JR_PREDICT = 1'b1,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic [31:0]      pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic [1:0]       res_kind,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_pred_target,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] is_jump;
  logic [TW-1:0]      tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];

  logic [IDX-1:0] fidx, ridx;
  logic [TW-1:0]  ftag, rtag;
  logic           fhit, rhit;
  logic           mispredict;
  logic [31:0]    redirect;

  assign fidx = pc[IDX+1:2];
  assign ftag = pc[31:IDX+2];
  assign ridx = res_pc[IDX+1:2];
  assign rtag = res_pc[31:IDX+2];

  assign fhit        = valid[fidx] && (tag[fidx] == ftag);
  assign rhit        = valid[ridx] && (tag[ridx] == rtag);
  assign pred_taken  = fhit && (is_jump[fidx] || ctr[fidx][1]);
  assign pred_target = pred_taken ? target[fidx] : pc + 32'd4;

  // Resolutions arriving while reset is asserted are ignored, including the flush.
  assign mispredict = reset && res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target)));
  assign redirect   = res_taken ? res_target : res_pc + 32'd4;
  assign flush      = mispredict;

  logic       alloc, bump, inval, alloc_jump;
  logic [1:0] alloc_ctr;

  always_comb begin
    alloc      = 1'b0;
    bump       = 1'b0;
    inval      = 1'b0;
    alloc_jump = 1'b0;
    alloc_ctr  = 2'b10;
    if (res_valid) begin
      case (res_kind)
        2'b01: begin
          if (rhit)           bump  = 1'b1;
          else if (res_taken) alloc = 1'b1;
        end
        2'b10: begin
          alloc      = 1'b1;
          alloc_ctr  = 2'b11;
          alloc_jump = 1'b1;
        end
        2'b11: begin
          if (JR_PREDICT) begin
            alloc      = 1'b1;
            alloc_ctr  = 2'b11;
            alloc_jump = 1'b1;
          end
        end
        default: inval = rhit;
      endcase
    end
  end

  // Mispredict redirect outranks the stall hold; the BTB write lands at the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc             <= RESET_PC;
      valid          <= '0;
      is_jump        <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b00;
    end else begin
      if (mispredict)  pc <= redirect;
      else if (!stall) pc <= pred_target;

      if (alloc) begin
        valid[ridx]   <= 1'b1;
        tag[ridx]     <= rtag;
        target[ridx]  <= res_target;
        ctr[ridx]     <= alloc_ctr;
        is_jump[ridx] <= alloc_jump;
      end else if (bump) begin
        if (res_taken) begin
          target[ridx] <= res_target;
          if (ctr[ridx] != 2'b11) ctr[ridx] <= ctr[ridx] + 2'd1;
        end else if (ctr[ridx] != 2'b00) begin
          ctr[ridx] <= ctr[ridx] - 2'd1;
        end
      end else if (inval) begin
        valid[ridx] <= 1'b0;
      end

      if (mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_npc_btb_predictor.sv
// Directed plus randomized bench for npc_btb_predictor: two instances (jr allocation on/off)
// share one stimulus stream and are compared against a behavioural BTB model each cycle.
module tb_npc_btb_predictor;

  localparam int          ENTRIES  = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, stall, res_valid, res_taken, res_pred_taken;
  logic [31:0]      res_pc, res_target, res_pred_target;
  logic [1:0]       res_kind;
  logic [31:0]      pcO [2];
  logic [31:0]      predTargetO [2];
  logic             predTakenO [2];
  logic             flushO [2];
  logic [CNT_W-1:0] cntO [2];

  int vectors     = 0;
  int miscompares = 0;

  // Model: each slot remembers the full PC of the instruction it was written for.
  bit          mValid [2][ENTRIES];
  logic [31:0] mOwner [2][ENTRIES];
  logic [31:0] mTarget[2][ENTRIES];
  int          mCtr   [2][ENTRIES];
  bit          mJump  [2][ENTRIES];
  logic [31:0] mPc    [2];
  int          mCnt   [2];

  npc_btb_predictor #(.ENTRIES(ENTRIES), .RESET_PC(RESET_PC), .JR_PREDICT(1'b1), .CNT_W(CNT_W)) u0 (
    .clk(clk), .reset(reset), .stall(stall), .pc(pcO[0]), .pred_taken(predTakenO[0]),
    .pred_target(predTargetO[0]), .res_valid(res_valid), .res_pc(res_pc), .res_kind(res_kind),
    .res_taken(res_taken), .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .flush(flushO[0]), .mispredict_cnt(cntO[0]));

  npc_btb_predictor #(.ENTRIES(ENTRIES), .RESET_PC(RESET_PC), .JR_PREDICT(1'b0), .CNT_W(CNT_W)) u1 (
    .clk(clk), .reset(reset), .stall(stall), .pc(pcO[1]), .pred_taken(predTakenO[1]),
    .pred_target(predTargetO[1]), .res_valid(res_valid), .res_pc(res_pc), .res_kind(res_kind),
    .res_taken(res_taken), .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .flush(flushO[1]), .mispredict_cnt(cntO[1]));

  always #5 clk = ~clk;

  function automatic int slotOf(logic [31:0] a);
    return int'(a[31:2] % ENTRIES);
  endfunction

  function automatic bit mHit(int i, logic [31:0] a);
    int k = slotOf(a);
    return mValid[i][k] && (mOwner[i][k][31:2] == a[31:2]);
  endfunction

  function automatic bit mPredTaken(int i, logic [31:0] a);
    int k = slotOf(a);
    return mHit(i, a) && (mJump[i][k] || mCtr[i][k] >= 2);
  endfunction

  function automatic logic [31:0] mPredTarget(int i, logic [31:0] a);
    return mPredTaken(i, a) ? mTarget[i][slotOf(a)] : a + 32'd4;
  endfunction

  function automatic bit mFlush();
    return reset && res_valid &&
           ((res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target));
  endfunction

  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      bit          mis;
      bit          h;
      int          k;
      logic [31:0] nextPc;
      if (!reset) begin
        mPc[i]  = RESET_PC;
        mCnt[i] = 0;
        for (int e = 0; e < ENTRIES; e++) begin
          mValid[i][e] = 1'b0;
          mCtr[i][e]   = 0;
        end
      end else begin
        mis = mFlush();
        if (mis)        nextPc = res_taken ? res_target : res_pc + 32'd4;
        else if (stall) nextPc = mPc[i];
        else            nextPc = mPredTarget(i, mPc[i]);
        k = slotOf(res_pc);
        h = mHit(i, res_pc);
        if (res_valid) begin
          if (res_kind == 2'b01 && h) begin
            mCtr[i][k] = res_taken ? ((mCtr[i][k] == 3) ? 3 : mCtr[i][k] + 1)
                                   : ((mCtr[i][k] == 0) ? 0 : mCtr[i][k] - 1);
            if (res_taken) mTarget[i][k] = res_target;
          end else if ((res_kind == 2'b01 && res_taken) || res_kind == 2'b10 ||
                       (res_kind == 2'b11 && i == 0)) begin
            mValid[i][k]  = 1'b1;
            mOwner[i][k]  = res_pc;
            mTarget[i][k] = res_target;
            mCtr[i][k]    = (res_kind == 2'b01) ? 2 : 3;
            mJump[i][k]   = (res_kind != 2'b01);
          end else if (res_kind == 2'b00 && h) begin
            mValid[i][k] = 1'b0;
          end
        end
        if (mis && mCnt[i] < CNT_MAX) mCnt[i]++;
        mPc[i] = nextPc;
      end
    end
  endtask

  task automatic checkValue(string tag, logic [31:0] observed, logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      checkValue($sformatf("pc[%0d]", i), pcO[i], mPc[i]);
      checkValue($sformatf("pred_taken[%0d]", i), 32'(predTakenO[i]), 32'(mPredTaken(i, mPc[i])));
      checkValue($sformatf("pred_target[%0d]", i), predTargetO[i], mPredTarget(i, mPc[i]));
      checkValue($sformatf("flush[%0d]", i), 32'(flushO[i]), 32'(mFlush()));
      checkValue($sformatf("cnt[%0d]", i), 32'(cntO[i]), 32'(mCnt[i]));
    end
  endtask

  task automatic applyStimulus(logic r, logic st, logic v, logic [31:0] rpc, logic [1:0] kind,
                               logic tk, logic [31:0] tgt, logic ptk, logic [31:0] ptgt);
    reset = r; stall = st; res_valid = v; res_pc = rpc; res_kind = kind;
    res_taken = tk; res_target = tgt; res_pred_taken = ptk; res_pred_target = ptgt;
  endtask

  task automatic stepCycle();
    #1;
    checkOutput();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0);
  endtask

  // Not-taken resolution at dest-4 with a taken prediction: forces fetch to dest.
  task automatic steer(logic [31:0] dest);
    applyStimulus(1, 0, 1, dest - 32'd4, 2'b01, 0, 32'h0, 1, dest);
  endtask

  logic [31:0] tgtPool [4];

  initial begin
    tgtPool[0] = 32'h3040; tgtPool[1] = 32'h3080; tgtPool[2] = 32'h4000; tgtPool[3] = 32'h3010;
    for (int i = 0; i < 2; i++) begin
      mPc[i] = 32'h0; mCnt[i] = 0;
      for (int e = 0; e < ENTRIES; e++) begin
        mValid[i][e] = 1'b0; mOwner[i][e] = 32'h0; mTarget[i][e] = 32'h0;
        mCtr[i][e] = 0; mJump[i][e] = 1'b0;
      end
    end

    applyStimulus(0, 0, 1, 32'h3010, 2'b10, 1, 32'h5000, 0, 32'h0);
    @(negedge clk);
    @(posedge clk); modelStep(); @(negedge clk);
    @(posedge clk); modelStep(); @(negedge clk);

    idle(); #1;
    checkValue("rst_pc", pcO[0], 32'h3000);
    checkValue("rst_pred_taken", 32'(predTakenO[0]), 32'h0);
    checkValue("rst_pred_target", predTargetO[0], 32'h3004);
    checkValue("rst_cnt", 32'(cntO[0]), 32'h0);
    stepCycle();

    applyStimulus(1, 0, 1, 32'h3010, 2'b01, 1, 32'h3040, 0, 32'h3014); #1;
    checkValue("seq_pc", pcO[0], 32'h3004);
    checkValue("cold_flush", 32'(flushO[0]), 32'h1);
    stepCycle();

    steer(32'h3010); #1;
    checkValue("cold_redirect", pcO[0], 32'h3040);
    checkValue("cold_cnt", 32'(cntO[0]), 32'h1);
    stepCycle();

    idle(); #1;
    checkValue("refetch_taken", 32'(predTakenO[0]), 32'h1);
    checkValue("refetch_target", predTargetO[0], 32'h3040);
    stepCycle();

    applyStimulus(1, 0, 1, 32'h3010, 2'b01, 0, 32'h3040, 1, 32'h3040); stepCycle();
    steer(32'h3010); stepCycle();
    applyStimulus(1, 0, 1, 32'h3010, 2'b01, 1, 32'h3040, 1, 32'h3040); #1;
    checkValue("hyst_pc", pcO[0], 32'h3010);
    checkValue("hyst_weak_nt", 32'(predTakenO[0]), 32'h0);
    checkValue("hyst_fallthru", predTargetO[0], 32'h3014);
    stepCycle();
    applyStimulus(1, 0, 1, 32'h3010, 2'b01, 1, 32'h3040, 1, 32'h3040); stepCycle();
    applyStimulus(1, 0, 1, 32'h3010, 2'b01, 1, 32'h3040, 1, 32'h3040); stepCycle();
    applyStimulus(1, 0, 1, 32'h3010, 2'b01, 0, 32'h3040, 1, 32'h3040); stepCycle();
    steer(32'h3010); stepCycle();
    idle(); #1;
    checkValue("sat_still_taken", 32'(predTakenO[0]), 32'h1);
    stepCycle();

    applyStimulus(1, 1, 1, 32'h3020, 2'b01, 0, 32'h3040, 1, 32'h3040); #1;
    checkValue("prio_flush", 32'(flushO[0]), 32'h1);
    stepCycle();
    idle(); #1;
    checkValue("prio_pc", pcO[0], 32'h3024);
    stepCycle();

    steer(32'h3050); stepCycle();
    applyStimulus(1, 0, 1, 32'h3050, 2'b00, 0, 32'h0, 0, 32'h3054); #1;
    checkValue("alias_pc", pcO[0], 32'h3050);
    checkValue("alias_miss", 32'(predTakenO[0]), 32'h0);
    stepCycle();
    steer(32'h3010); stepCycle();
    idle(); #1;
    checkValue("alias_kept", predTargetO[0], 32'h3040);
    stepCycle();

    applyStimulus(1, 0, 1, 32'h3008, 2'b11, 1, 32'h4000, 0, 32'h300c); #1;
    checkValue("jr_flush_nopred", 32'(flushO[1]), 32'h1);
    stepCycle();
    steer(32'h3008); stepCycle();
    applyStimulus(1, 0, 1, 32'h3008, 2'b11, 1, 32'h4000, 0, 32'h300c); #1;
    checkValue("jr_hit_pred", predTargetO[0], 32'h4000);
    checkValue("jr_nopred_pc", pcO[1], 32'h3008);
    checkValue("jr_nopred_miss", 32'(predTakenO[1]), 32'h0);
    checkValue("jr_flush_again", 32'(flushO[1]), 32'h1);
    stepCycle();
    idle(); #1;
    checkValue("jr_redirect", pcO[1], 32'h4000);
    stepCycle();

    for (int n = 0; n < 4; n++) begin
      steer(32'h2004); stepCycle();
    end
    idle(); #1;
    checkValue("cnt_saturated", 32'(cntO[0]), 32'(CNT_MAX));
    stepCycle();

    for (int n = 0; n < 600; n++) begin
      logic [1:0]  kind;
      logic        tk;
      logic [31:0] rpc;
      kind = 2'($urandom_range(0, 3));
      rpc  = 32'h3000 + 32'($urandom_range(0, 47)) * 32'd4;
      tk   = (kind == 2'b01) ? 1'($urandom) : (kind != 2'b00);
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) != 0), rpc, kind, tk, tgtPool[$urandom_range(0, 3)],
                    1'($urandom),
                    ($urandom_range(0, 4) == 0) ? rpc + 32'd4 : tgtPool[$urandom_range(0, 3)]);
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
